// File: rtl/i2c_reg_target_pkg.sv
// Shared types and constants for the I2C register target: FSM state encoding,
// ACK/NACK bit levels and the R/W bit values of the address byte.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } i2c_tgt_state_e;

   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;
   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   // Busy covers everything from our address match until the transaction ends.
   function automatic logic is_busy_state(input logic [3:0] s);
      return !((s == ST_IDLE) || (s == ST_ADDR) || (s == ST_IGNORE));
   endfunction

endpackage

// File: rtl/i2c_reg_target_if.sv
// Host register port of the I2C target: write strobe out, read address out,
// read data back in from the host register file.
interface i2c_reg_target_if #(
   parameter int unsigned REG_AW = 2
) ();
   // wr_valid is a one-cycle strobe with no back-pressure: wr_addr/wr_data are
   // valid only in that cycle. rd_data must reflect rd_addr combinationally.
   logic              wr_valid;
   logic [REG_AW-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [REG_AW-1:0] rd_addr;
   logic [7:0]        rd_data;

   modport master (output wr_valid, wr_addr, wr_data, rd_addr, input rd_data);
   modport slave  (input wr_valid, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/i2c_reg_target_sync.sv
// Bus front end: 2-flop synchronizers on SCL/SDA followed by one-flop edge
// detection producing SCL edges and START/STOP conditions.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   logic [1:0] scl_meta_q, sda_meta_q;
   logic       scl_p_q, sda_p_q;
   logic       scl_s;

   // Idle bus level is high, so everything resets to 1 to avoid false edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_meta_q <= 2'b11;
         sda_meta_q <= 2'b11;
         scl_p_q    <= 1'b1;
         sda_p_q    <= 1'b1;
      end else begin
         scl_meta_q <= {scl_meta_q[0], scl_in};
         sda_meta_q <= {sda_meta_q[0], sda_in};
         scl_p_q    <= scl_meta_q[1];
         sda_p_q    <= sda_meta_q[1];
      end
   end

   assign scl_s     = scl_meta_q[1];
   assign sda_s     = sda_meta_q[1];
   assign scl_rise  = scl_s & ~scl_p_q;
   assign scl_fall  = ~scl_s & scl_p_q;
   assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
   assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;
endmodule

// File: rtl/i2c_reg_target.sv
// I2C target bridging addr+W/ptr/data writes and addr+R streaming reads onto a
// small host register port; SDA is driven open-drain, SCL is never driven.
module i2c_reg_target
   import i2c_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = 7'h01,
   parameter int unsigned REG_AW      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              busy,
   output logic              ack_error,
   output logic [3:0]        dbg_state,
   i2c_reg_target_if.master  reg_if
);
   localparam logic [3:0] S_IDLE      = ST_IDLE;
   localparam logic [3:0] S_ADDR      = ST_ADDR;
   localparam logic [3:0] S_ADDR_ACK  = ST_ADDR_ACK;
   localparam logic [3:0] S_PTR       = ST_PTR;
   localparam logic [3:0] S_PTR_ACK   = ST_PTR_ACK;
   localparam logic [3:0] S_WDATA     = ST_WDATA;
   localparam logic [3:0] S_WDATA_ACK = ST_WDATA_ACK;
   localparam logic [3:0] S_RDATA     = ST_RDATA;
   localparam logic [3:0] S_RDATA_ACK = ST_RDATA_ACK;

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   logic [3:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [REG_AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              rw_q, rw_d, sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d;
   logic              ack_err_q, ack_err_d, ld_pend_q, ld_pend_d;
   logic [7:0]        rx_byte;

   assign rx_byte = {shift_q[6:0], sda_s};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      ack_err_d  = ack_err_q;
      ld_pend_d  = ld_pend_q;

      // Contention: we pull low but the bus still reads high at the sample point.
      if (scl_rise && sda_oe_q && sda_s) ack_err_d = 1'b1;

      case (state_q)
         S_ADDR: if (scl_rise) begin
            shift_d = rx_byte;
            if (cnt_q == 3'd0) begin
               if (rx_byte[7:1] == TARGET_ADDR) begin
                  rw_d    = rx_byte[0];
                  state_d = S_ADDR_ACK;
               end else begin
                  state_d = ST_IGNORE;
               end
            end else cnt_d = cnt_q - 3'd1;
         end
         S_PTR, S_WDATA: if (scl_rise) begin
            shift_d = rx_byte;
            if (cnt_q == 3'd0) begin
               if (state_q == S_PTR) begin
                  ptr_d   = rx_byte[REG_AW-1:0];
                  state_d = S_PTR_ACK;
               end else begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte;
                  ptr_d      = ptr_q + 1'b1;
                  state_d    = S_WDATA_ACK;
               end
            end else cnt_d = cnt_q - 3'd1;
         end
         // First scl_fall starts the ACK, second one (after one SCL high) ends it.
         S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
               sda_oe_d = 1'b1;
            end else begin
               sda_oe_d = 1'b0;
               cnt_d    = 3'd7;
               if (state_q == S_ADDR_ACK && rw_q == I2C_RW_READ) begin
                  shift_d  = reg_if.rd_data;
                  sda_oe_d = ~reg_if.rd_data[7];
                  state_d  = S_RDATA;
               end else if (state_q == S_ADDR_ACK) begin
                  state_d = S_PTR;
               end else begin
                  state_d = S_WDATA;
               end
            end
         end
         S_RDATA: if (scl_fall) begin
            if (cnt_q == 3'd0) begin
               sda_oe_d  = 1'b0;
               ld_pend_d = 1'b0;
               state_d   = S_RDATA_ACK;
            end else begin
               cnt_d    = cnt_q - 3'd1;
               shift_d  = {shift_q[6:0], shift_q[7]};
               sda_oe_d = ~shift_q[6];
            end
         end
         S_RDATA_ACK: begin
            if (scl_rise) begin
               if (sda_s == I2C_ACK) begin
                  ptr_d     = ptr_q + 1'b1;
                  ld_pend_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            if (scl_fall && ld_pend_q) begin
               shift_d   = reg_if.rd_data;
               sda_oe_d  = ~reg_if.rd_data[7];
               cnt_d     = 3'd7;
               ld_pend_d = 1'b0;
               state_d   = S_RDATA;
            end
         end
         default: ;
      endcase

      if (start_det) begin
         state_d   = S_ADDR;
         cnt_d     = 3'd7;
         sda_oe_d  = 1'b0;
         ack_err_d = 1'b0;
         ld_pend_d = 1'b0;
      end else if (stop_det) begin
         state_d   = S_IDLE;
         sda_oe_d  = 1'b0;
         ld_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd7;
         shift_q    <= 8'h00;
         ptr_q      <= '0;
         rw_q       <= I2C_RW_WRITE;
         sda_oe_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
         ack_err_q  <= 1'b0;
         ld_pend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         ack_err_q  <= ack_err_d;
         ld_pend_q  <= ld_pend_d;
      end
   end

   assign sda_oe          = sda_oe_q;
   assign busy            = is_busy_state(state_q);
   assign ack_error       = ack_err_q;
   assign dbg_state       = state_q;
   assign reg_if.wr_valid = wr_valid_q;
   assign reg_if.wr_addr  = wr_addr_q;
   assign reg_if.wr_data  = wr_data_q;
   assign reg_if.rd_addr  = ptr_q;
endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a bit-banged I2C master, a host register model and
// a transaction-level reference of the pointer and expected register writes.
module tb_i2c_reg_target;
   import i2c_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl_m = 1'b1, sda_m = 1'b1, force_hi = 1'b0;
   logic sda_line, sda_oe, busy, ack_error;
   logic [3:0] dbg_state;
   logic [7:0] regs [4];
   logic [9:0] exp_q [$];
   logic [9:0] got_q [$];
   logic [1:0] m_ptr = 2'd0;
   logic oe_seen = 1'b0, oe_prev = 1'b0;
   int oe_viol = 0;
   int checks = 0, failures = 0;

   i2c_reg_target_if #(.REG_AW(2)) reg_if ();

   i2c_reg_target #(.TARGET_ADDR(7'h01), .REG_AW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .ack_error (ack_error),
      .dbg_state (dbg_state),
      .reg_if    (reg_if)
   );

   // Clock and reset
   always #5 clk = ~clk;
   assign sda_line = force_hi ? 1'b1 : (sda_m & ~sda_oe);
   assign reg_if.rd_data = regs[reg_if.rd_addr];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Observed-write capture and SDA drive-timing monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (reg_if.wr_valid) got_q.push_back({reg_if.wr_addr, reg_if.wr_data});
         if (sda_oe) oe_seen = 1'b1;
         if (sda_oe !== oe_prev && scl_m) oe_viol++;
      end
      oe_prev = sda_oe;
   end

   // Master driver tasks
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (scl_m == 1'b0) begin
         sda_m = 1'b1; clks(4);
         scl_m = 1'b1; clks(8);
      end
      sda_m = 1'b0; clks(8);
      scl_m = 1'b0; clks(4);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; clks(4);
      scl_m = 1'b1; clks(8);
      sda_m = 1'b1; clks(8);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      sda_m = b;    clks(4);
      scl_m = 1'b1; clks(4);
      s = sda_line; clks(4);
      scl_m = 1'b0; clks(4);
   endtask

   task automatic bus_write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
      bus_bit(1'b1, s);
      ack = (s == I2C_ACK);
   endtask

   task automatic bus_read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         d[i] = s;
      end
      bus_bit(mack ? I2C_ACK : I2C_NACK, s);
   endtask

   // Tests
   task automatic test_reset();
      checks += 8;
      if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
      if (reg_if.wr_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_valid: got %b want 0", reg_if.wr_valid); end
      if (reg_if.wr_addr !== 2'd0) begin failures++; $display("FAIL rst_wr_addr: got %0d want 0", reg_if.wr_addr); end
      if (reg_if.wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr_data: got %h want 00", reg_if.wr_data); end
      if (reg_if.rd_addr !== 2'd0) begin failures++; $display("FAIL rst_rd_addr: got %0d want 0", reg_if.rd_addr); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (ack_error !== 1'b0) begin failures++; $display("FAIL rst_ack_error: got %b want 0", ack_error); end
      if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_write();
      logic ack;
      logic [7:0] bytes [4] = '{8'h02, 8'h01, 8'hAA, 8'h55};
      bus_start();
      for (int i = 0; i < 4; i++) begin
         bus_write_byte(bytes[i], ack);
         checks++;
         if (ack !== 1'b1) begin failures++; $display("FAIL write_ack%0d: got %b want 1", i, ack); end
         if (i == 0) begin
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b want 1", busy); end
         end
      end
      exp_q.push_back({2'd1, 8'hAA});
      exp_q.push_back({2'd2, 8'h55});
      m_ptr = 2'd3;
      bus_stop();
      clks(4);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_stop: got %b want 0", busy); end
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL write_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL write_item%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] d;
      regs = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus_start();
      bus_write_byte(8'h02, ack);
      bus_write_byte(8'h03, ack);
      bus_start();
      bus_write_byte(8'h03, ack);
      checks++;
      if (ack !== 1'b1) begin failures++; $display("FAIL read_addr_ack: got %b want 1", ack); end
      bus_read_byte(1'b1, d);
      checks++;
      if (d !== 8'h44) begin failures++; $display("FAIL read_byte0: got %h want 44", d); end
      bus_read_byte(1'b0, d);
      checks++;
      if (d !== 8'h11) begin failures++; $display("FAIL read_byte1_wrap: got %h want 11", d); end
      m_ptr = 2'd0;
      clks(2);
      checks += 3;
      if (sda_oe !== 1'b0) begin failures++; $display("FAIL read_release: got %b want 0", sda_oe); end
      if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_nack: got %b want 0", busy); end
      if (ack_error !== 1'b0) begin failures++; $display("FAIL read_ack_error: got %b want 0", ack_error); end
      bus_stop();
      checks++;
      if (reg_if.rd_addr !== m_ptr) begin failures++; $display("FAIL read_ptr: got %0d want %0d", reg_if.rd_addr, m_ptr); end
   endtask

   task automatic test_mismatch();
      logic ack;
      oe_seen = 1'b0;
      bus_start();
      bus_write_byte(8'h06, ack);
      checks += 2;
      if (ack !== 1'b0) begin failures++; $display("FAIL mism_addr_ack: got %b want 0", ack); end
      if (busy !== 1'b0) begin failures++; $display("FAIL mism_busy: got %b want 0", busy); end
      bus_write_byte(8'hBB, ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL mism_data_ack: got %b want 0", ack); end
      bus_stop();
      clks(4);
      checks += 3;
      if (oe_seen !== 1'b0) begin failures++; $display("FAIL mism_oe: got %b want 0", oe_seen); end
      if (got_q.size() != 0) begin failures++; $display("FAIL mism_writes: got %0d want 0", got_q.size()); end
      if (reg_if.rd_addr !== m_ptr) begin failures++; $display("FAIL mism_ptr: got %0d want %0d", reg_if.rd_addr, m_ptr); end
      got_q.delete();
   endtask

   task automatic test_wrap();
      logic ack;
      bus_start();
      bus_write_byte(8'h02, ack);
      bus_write_byte(8'h03, ack);
      bus_write_byte(8'h01, ack);
      bus_write_byte(8'h02, ack);
      bus_stop();
      exp_q.push_back({2'd3, 8'h01});
      exp_q.push_back({2'd0, 8'h02});
      bus_start();
      bus_write_byte(8'h02, ack);
      bus_write_byte(8'hFD, ack);
      checks++;
      if (reg_if.rd_addr !== 2'd1) begin failures++; $display("FAIL wrap_ptr_fd: got %0d want 1", reg_if.rd_addr); end
      bus_write_byte(8'h5A, ack);
      bus_stop();
      exp_q.push_back({2'd1, 8'h5A});
      m_ptr = 2'd2;
      clks(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_item%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_abort();
      logic ack, s;
      bus_start();
      bus_write_byte(8'h02, ack);
      bus_write_byte(8'h02, ack);
      m_ptr = 2'd2;
      for (int i = 0; i < 4; i++) bus_bit(1'(i & 1), s);
      bus_stop();
      clks(4);
      checks += 3;
      if (got_q.size() != 0) begin failures++; $display("FAIL abort_writes: got %0d want 0", got_q.size()); end
      if (reg_if.rd_addr !== m_ptr) begin failures++; $display("FAIL abort_ptr: got %0d want %0d", reg_if.rd_addr, m_ptr); end
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
      got_q.delete();
      bus_start();
      bus_write_byte(8'h02, ack);
      bus_write_byte(8'h00, ack);
      bus_write_byte(8'h77, ack);
      bus_stop();
      m_ptr = 2'd1;
      clks(4);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {2'd0, 8'h77}) begin
         failures++;
         $display("FAIL abort_next_write: got %0d items first %h want 1 item %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, {2'd0, 8'h77});
      end
      got_q.delete();
   endtask

   task automatic test_contention();
      logic ack;
      logic [7:0] d;
      regs[2] = 8'h00;
      bus_start();
      bus_write_byte(8'h02, ack);
      bus_write_byte(8'h02, ack);
      bus_start();
      bus_write_byte(8'h03, ack);
      force_hi = 1'b1;
      bus_read_byte(1'b0, d);
      force_hi = 1'b0;
      m_ptr = 2'd2;
      checks++;
      if (ack_error !== 1'b1) begin failures++; $display("FAIL cont_set: got %b want 1", ack_error); end
      bus_stop();
      clks(4);
      checks++;
      if (ack_error !== 1'b1) begin failures++; $display("FAIL cont_sticky: got %b want 1", ack_error); end
      bus_start();
      checks++;
      if (ack_error !== 1'b0) begin failures++; $display("FAIL cont_clear: got %b want 0", ack_error); end
      bus_stop();
   endtask

   task automatic test_random();
      logic ack, match;
      logic [6:0] a;
      logic [7:0] p, d, rd;
      int n;
      for (int t = 0; t < 10; t++) begin
         if ($urandom_range(0, 1) == 0) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h01;
            match = (a == 7'h01);
            p = 8'($urandom);
            n = $urandom_range(0, 3);
            bus_start();
            bus_write_byte({a, I2C_RW_WRITE}, ack);
            checks++;
            if (ack !== match) begin failures++; $display("FAIL rnd%0d_addr_ack: got %b want %b", t, ack, match); end
            bus_write_byte(p, ack);
            if (match) m_ptr = p[1:0];
            for (int i = 0; i < n; i++) begin
               d = 8'($urandom);
               bus_write_byte(d, ack);
               checks++;
               if (ack !== match) begin failures++; $display("FAIL rnd%0d_data_ack%0d: got %b want %b", t, i, ack, match); end
               if (match) begin
                  exp_q.push_back({m_ptr, d});
                  m_ptr = m_ptr + 2'd1;
               end
            end
            bus_stop();
         end else begin
            for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
            p = 8'($urandom);
            n = $urandom_range(1, 3);
            bus_start();
            bus_write_byte(8'h02, ack);
            bus_write_byte(p, ack);
            m_ptr = p[1:0];
            bus_start();
            bus_write_byte({7'h01, I2C_RW_READ}, ack);
            for (int i = 0; i < n; i++) begin
               bus_read_byte(i < n - 1, rd);
               checks++;
               if (rd !== regs[m_ptr]) begin failures++; $display("FAIL rnd%0d_rd%0d: got %h want %h", t, i, rd, regs[m_ptr]); end
               if (i < n - 1) m_ptr = m_ptr + 2'd1;
            end
            bus_stop();
         end
         clks(4);
         checks++;
         if (reg_if.rd_addr !== m_ptr) begin failures++; $display("FAIL rnd%0d_ptr: got %0d want %0d", t, reg_if.rd_addr, m_ptr); end
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_item%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_mid();
      logic s;
      int waited = 0;
      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(((8'h02 >> i) & 8'h01) != 0, s);
      while (sda_oe !== 1'b1 && waited < 20) begin
         clks(1);
         waited++;
      end
      checks++;
      if (sda_oe !== 1'b1) begin failures++; $display("FAIL rstmid_ack_drive: got %b want 1", sda_oe); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (sda_oe !== 1'b0) begin failures++; $display("FAIL rstmid_release: got %b want 0", sda_oe); end
      m_ptr = 2'd0;
      test_reset();
      scl_m = 1'b1; sda_m = 1'b1;
      clks(4);
      rst_n = 1'b1;
      clks(4);
      checks++;
      if (oe_viol != 0) begin failures++; $display("FAIL oe_timing: got %0d changes while SCL high want 0", oe_viol); end
   endtask

   initial begin
      regs = '{8'h00, 8'h00, 8'h00, 8'h00};
      clks(3);
      test_reset();
      rst_n = 1'b1;
      clks(4);
      test_write();
      test_read();
      test_mismatch();
      test_wrap();
      test_abort();
      test_contention();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
